// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-phase sequencer (IDLE/LOAD/EXEC/DONE) driving an external ALU.
// Define ALU_SEQ_FLAGS_EN to register the ALU negative/zero flags on legal operations.
module alu_sequencer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [2:0] i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_alu_a,
  output logic [7:0] o_alu_b,
  output logic       o_alu_bWr,
  output logic       o_alu_oe,
  output logic       o_alu_subShiftDir,
  output logic [1:0] o_alu_op,
  input  logic [7:0] i_alu_y,
  input  logic       i_alu_negative,
  input  logic       i_alu_zero,
  output logic       o_result_valid,
  input  logic       i_result_ready,
  output logic [7:0] o_result,
  output logic       o_illegal,
  output logic       o_negative,
  output logic       o_zero
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DONE} state_t;

  state_t     r_state;
  logic [2:0] r_op;
  logic [7:0] r_a;

  logic       w_in_legal;
  logic       w_in_shift;
  logic       w_legal;
  logic [1:0] w_op_sel;
  logic       w_dir;

  // Outputs are registered, so LOAD-phase values are decoded from the incoming request.
  assign w_in_legal = (i_op[2:1] != 2'b11);
  assign w_in_shift = (i_op[2:1] == 2'b10);
  assign w_legal    = (r_op[2:1] != 2'b11);

  always_comb begin
    w_op_sel = 2'b00;
    w_dir    = 1'b0;
    case (r_op)
      3'b000:  begin w_op_sel = 2'b00; w_dir = 1'b0; end
      3'b001:  begin w_op_sel = 2'b00; w_dir = 1'b1; end
      3'b010:  begin w_op_sel = 2'b01; w_dir = 1'b0; end
      3'b011:  begin w_op_sel = 2'b10; w_dir = 1'b0; end
      3'b100:  begin w_op_sel = 2'b11; w_dir = 1'b1; end
      3'b101:  begin w_op_sel = 2'b11; w_dir = 1'b0; end
      default: begin w_op_sel = 2'b00; w_dir = 1'b0; end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state           <= S_IDLE;
      r_op              <= 3'b000;
      r_a               <= 8'h00;
      o_ready           <= 1'b1;
      o_alu_a           <= 8'h00;
      o_alu_b           <= 8'h00;
      o_alu_bWr         <= 1'b0;
      o_alu_oe          <= 1'b0;
      o_alu_subShiftDir <= 1'b0;
      o_alu_op          <= 2'b00;
      o_result_valid    <= 1'b0;
      o_result          <= 8'h00;
      o_illegal         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_op      <= i_op;
            r_a       <= i_a;
            o_ready   <= 1'b0;
            // Shift amounts only use B[2:0]; the upper bits never reach the ALU.
            o_alu_b   <= w_in_shift ? {5'd0, i_b[2:0]} : i_b;
            o_alu_bWr <= w_in_legal;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          o_alu_b           <= 8'h00;
          o_alu_bWr         <= 1'b0;
          o_alu_a           <= r_a;
          o_alu_op          <= w_op_sel;
          o_alu_subShiftDir <= w_dir;
          o_alu_oe          <= w_legal;
          r_state           <= S_EXEC;
        end
        S_EXEC: begin
          o_alu_a           <= 8'h00;
          o_alu_op          <= 2'b00;
          o_alu_subShiftDir <= 1'b0;
          o_alu_oe          <= 1'b0;
          o_result          <= w_legal ? i_alu_y : 8'h00;
          o_illegal         <= ~w_legal;
          o_result_valid    <= 1'b1;
          r_state           <= S_DONE;
        end
        S_DONE: begin
          if (i_result_ready) begin
            o_result_valid <= 1'b0;
            o_ready        <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic r_negative;
  logic r_zero;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_negative <= 1'b0;
      r_zero     <= 1'b0;
    end else if (r_state == S_EXEC && w_legal) begin
      r_negative <= i_alu_negative;
      r_zero     <= i_alu_zero;
    end
  end

  assign o_negative = r_negative;
  assign o_zero     = r_zero;
`else
  logic w_unused_flags;
  assign w_unused_flags = ^{i_alu_negative, i_alu_zero};
  assign o_negative     = 1'b0;
  assign o_zero         = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed bench for alu_sequencer with an external ALU model.
module tb_alu_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_valid;
  logic       o_ready;
  logic [2:0] i_op;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic       o_alu_bWr;
  logic       o_alu_oe;
  logic       o_alu_subShiftDir;
  logic [1:0] o_alu_op;
  logic [7:0] i_alu_y;
  logic       i_alu_negative;
  logic       i_alu_zero;
  logic       o_result_valid;
  logic       i_result_ready;
  logic [7:0] o_result;
  logic       o_illegal;
  logic       o_negative;
  logic       o_zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  alu_sequencer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_bWr(o_alu_bWr), .o_alu_oe(o_alu_oe),
    .o_alu_subShiftDir(o_alu_subShiftDir), .o_alu_op(o_alu_op),
    .i_alu_y(i_alu_y), .i_alu_negative(i_alu_negative), .i_alu_zero(i_alu_zero),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
    .o_result(o_result), .o_illegal(o_illegal), .o_negative(o_negative), .o_zero(o_zero)
  );

  // External ALU: B register written by bWr, result always driven so illegal ops see junk.
  logic [7:0] alu_breg = 8'h00;
  always @(posedge i_clk) if (o_alu_bWr) alu_breg <= o_alu_b;
  always_comb begin
    case (o_alu_op)
      2'b00:   i_alu_y = o_alu_subShiftDir ? o_alu_a - alu_breg : o_alu_a + alu_breg;
      2'b01:   i_alu_y = o_alu_a & alu_breg;
      2'b10:   i_alu_y = o_alu_a ^ alu_breg;
      default: i_alu_y = o_alu_subShiftDir ? o_alu_a << alu_breg : o_alu_a >> alu_breg;
    endcase
    i_alu_negative = i_alu_y[7];
    i_alu_zero     = (i_alu_y == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [2:0] op);
    return op < 3'd6;
  endfunction

  function automatic logic [7:0] spec_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a ^ b;
      3'd4:    return a << b[2:0];
      3'd5:    return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] spec_sel(input logic [2:0] op);
    case (op)
      3'd0:    return 3'b000;
      3'd1:    return 3'b001;
      3'd2:    return 3'b010;
      3'd3:    return 3'b100;
      3'd4:    return 3'b111;
      default: return 3'b110;
    endcase
  endfunction

  // Reference model: cycles since acceptance plus the spec's arithmetic.
  bit         chk_en = 0;
  int         m_phase = 0;
  logic [2:0] m_op = 3'd0;
  logic [7:0] m_a = 8'h00, m_b = 8'h00, m_res = 8'h00;
  logic       m_ill = 1'b0, m_neg = 1'b0, m_zero = 1'b0;

  always @(posedge i_clk) begin
    if (i_reset) begin
      chk_en = 1;
      m_phase = 0; m_res = 8'h00; m_ill = 1'b0; m_neg = 1'b0; m_zero = 1'b0;
    end else begin
      case (m_phase)
        0: if (i_valid) begin m_op = i_op; m_a = i_a; m_b = i_b; m_phase = 1; end
        1: m_phase = 2;
        2: begin
          m_res = spec_result(m_op, m_a, m_b);
          m_ill = !is_legal(m_op);
`ifdef ALU_SEQ_FLAGS_EN
          if (is_legal(m_op)) begin m_neg = m_res[7]; m_zero = (m_res == 8'h00); end
`endif
          m_phase = 3;
        end
        default: if (i_result_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("ready", o_ready, m_phase == 0);
      chk("result_valid", o_result_valid, m_phase == 3);
      chk("result", o_result, m_res);
      chk("illegal", o_illegal, m_ill);
      chk("negative", o_negative, m_neg);
      chk("zero", o_zero, m_zero);
      chk("bWr", o_alu_bWr, m_phase == 1 && is_legal(m_op));
      chk("oe", o_alu_oe, m_phase == 2 && is_legal(m_op));
      if (m_phase == 1 && is_legal(m_op))
        chk("alu_b", o_alu_b, (m_op == 3'd4 || m_op == 3'd5) ? {5'd0, m_b[2:0]} : m_b);
      if (m_phase == 2 && is_legal(m_op)) begin
        chk("alu_a", o_alu_a, m_a);
        chk("alu_sel", {o_alu_op, o_alu_subShiftDir}, spec_sel(m_op));
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input logic exp_ill, input int hold);
    int n;
    i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_op = 3'd7; i_a = 8'hEE; i_b = 8'hEE;
    n = 1;
    while (!o_result_valid && n < 10) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("latency", n, 3);
    chk("result_lit", o_result, exp_res);
    chk("illegal_lit", o_illegal, exp_ill);
    for (int k = 0; k < hold; k++) begin
      i_valid = 1'b1; i_op = 3'($urandom_range(0, 5)); i_a = 8'($urandom); i_b = 8'($urandom);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    chk("held_result", o_result, exp_res);
    chk("held_valid", o_result_valid, 1);
    i_result_ready = 1'b1;
    @(posedge i_clk); #1;
    i_result_ready = 1'b0;
    chk("ready_after", o_ready, 1);
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_op = 3'd0; i_a = 8'h00; i_b = 8'h00; i_result_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    chk("rst_ready", o_ready, 1);
    chk("rst_alu", {o_alu_a, o_alu_b, o_alu_bWr, o_alu_oe, o_alu_subShiftDir, o_alu_op}, 0);
    chk("rst_out", {o_result_valid, o_result, o_illegal, o_negative, o_zero}, 0);

    run_op(3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("add_flags", {o_negative, o_zero}, 2'b10);
`else
    chk("add_flags", {o_negative, o_zero}, 2'b00);
`endif
    run_op(3'd1, 8'h05, 8'h05, 8'h00, 1'b0, 0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("sub_flags", {o_negative, o_zero}, 2'b01);
`else
    chk("sub_flags", {o_negative, o_zero}, 2'b00);
`endif
    run_op(3'd4, 8'h81, 8'h01, 8'h02, 1'b0, 0);
    run_op(3'd5, 8'h80, 8'h09, 8'h40, 1'b0, 0);
    run_op(3'd7, 8'h80, 8'h33, 8'h00, 1'b1, 0);
    chk("ill_flags", {o_negative, o_zero}, 2'b00);
    run_op(3'd6, 8'h12, 8'h34, 8'h00, 1'b1, 0);
    run_op(3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 5);
    run_op(3'd3, 8'hAA, 8'h0F, 8'hA5, 1'b0, 1);

    // Abort in EXEC with a concurrent request that must be dropped.
    i_op = 3'd0; i_a = 8'h11; i_b = 8'h22; i_valid = 1'b1;
    @(posedge i_clk); #1 i_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("exec_oe", o_alu_oe, 1);
    i_reset = 1'b1; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_valid = 1'b0;
    chk("abort_ready", o_ready, 1);
    chk("abort_alu", {o_alu_a, o_alu_b, o_alu_bWr, o_alu_oe, o_alu_subShiftDir, o_alu_op}, 0);
    chk("abort_out", {o_result_valid, o_result, o_illegal, o_negative, o_zero}, 0);
    repeat (3) @(posedge i_clk);
    #1 chk("abort_no_valid", o_result_valid, 0);

    // Request in the same cycle as reset while idle.
    i_reset = 1'b1; i_valid = 1'b1; i_op = 3'd0; i_a = 8'h01; i_b = 8'h01;
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("rst_req_dropped", {o_ready, o_alu_bWr}, 2'b10);

    run_op(3'd0, 8'hFF, 8'h01, 8'h00, 1'b0, 0);
    repeat (2) @(posedge i_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
